// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: a per-register countdown of cycles until a
// result can be forwarded. It drives the ID stall and a stall-cause code,
// and keeps a saturating stalled-cycle counter.
module hazard_scoreboard #(
    parameter int NREG     = 32,
    parameter int RW       = 5,
    parameter int ALU_LAT  = 1,
    parameter int LOAD_LAT = 2,
    parameter int CNT_W    = 3,
    parameter int PERF_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ID_valid,
    input  logic [RW-1:0]     ID_rs,
    input  logic [RW-1:0]     ID_rt,
    input  logic              ID_useRs,
    input  logic              ID_useRt,
    input  logic [RW-1:0]     ID_rw,
    input  logic              ID_regWrite,
    input  logic              ID_memToReg,
    input  logic              ID_uncertainJump,
    input  logic              ID_flush,
    output logic              stall,
    output logic [1:0]        stall_cause,
    output logic [PERF_W-1:0] stall_cycles,
    output logic [NREG-1:0]   pend_mask
);

    logic [CNT_W-1:0]  cnt_q [NREG];
    logic [CNT_W-1:0]  cnt_d [NREG];
    logic [NREG-1:0]   ld_q, ld_d;
    logic [PERF_W-1:0] stall_cycles_q, stall_cycles_d;

    logic [CNT_W-1:0]  need;
    logic [CNT_W-1:0]  rs_cnt, rt_cnt;
    logic              rs_ld, rt_ld;
    logic              rs_haz, rt_haz;
    logic [1:0]        rs_cause, rt_cause;
    logic              issue;

    // Cause for one hazardous source: loads dominate, then branch-on-ALU.
    // A non-branch stalled by a non-load (only possible with ALU_LAT > 1)
    // is reported as an ALU dependency.
    function automatic logic [1:0] src_cause(input logic haz, input logic ld,
                                             input logic br);
        if (!haz)
            return 2'd0;
        if (ld)
            return br ? 2'd3 : 2'd2;
        return 2'd1;
    endfunction

    // Look up the countdown of each source; indices outside the file read as idle.
    always_comb begin
        rs_cnt = '0;
        rs_ld  = 1'b0;
        rt_cnt = '0;
        rt_ld  = 1'b0;
        if (int'(ID_rs) < NREG) begin
            rs_cnt = cnt_q[ID_rs];
            rs_ld  = ld_q[ID_rs];
        end
        if (int'(ID_rt) < NREG) begin
            rt_cnt = cnt_q[ID_rt];
            rt_ld  = ld_q[ID_rt];
        end
    end

    // Hazard detection: branches resolved in ID need the value one cycle earlier.
    always_comb begin
        need     = ID_uncertainJump ? '0 : CNT_W'(1);
        rs_haz   = ID_valid && !ID_flush && ID_useRs && (ID_rs != '0) && (rs_cnt > need);
        rt_haz   = ID_valid && !ID_flush && ID_useRt && (ID_rt != '0) && (rt_cnt > need);
        rs_cause = src_cause(rs_haz, rs_ld, ID_uncertainJump);
        rt_cause = src_cause(rt_haz, rt_ld, ID_uncertainJump);
        stall       = rs_haz || rt_haz;
        stall_cause = (rs_cause > rt_cause) ? rs_cause : rt_cause;
    end

    // Next scoreboard state: decrement everything, then a fresh issue overwrites.
    always_comb begin
        issue = ID_valid && !ID_flush && !stall && (ID_rw != '0) && (int'(ID_rw) < NREG);
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = cnt_q[r];
            ld_d[r]  = ld_q[r];
            if (cnt_q[r] != '0) begin
                cnt_d[r] = cnt_q[r] - CNT_W'(1);
                if (cnt_q[r] == CNT_W'(1))
                    ld_d[r] = 1'b0;
            end
            if (issue && (int'(ID_rw) == r)) begin
                if (ID_memToReg) begin
                    cnt_d[r] = CNT_W'(LOAD_LAT);
                    ld_d[r]  = 1'b1;
                end else if (ID_regWrite) begin
                    cnt_d[r] = CNT_W'(ALU_LAT);
                    ld_d[r]  = 1'b0;
                end
            end
        end
        cnt_d[0] = '0;
        ld_d[0]  = 1'b0;
        stall_cycles_d = stall_cycles_q;
        if (stall && (stall_cycles_q != '1))
            stall_cycles_d = stall_cycles_q + PERF_W'(1);
    end

    // Scoreboard and performance counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++)
                cnt_q[r] <= '0;
            ld_q           <= '0;
            stall_cycles_q <= '0;
        end else begin
            for (int r = 0; r < NREG; r++)
                cnt_q[r] <= cnt_d[r];
            ld_q           <= ld_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    // Pending mask mirrors which countdowns are still running.
    always_comb begin
        for (int r = 0; r < NREG; r++)
            pend_mask[r] = (cnt_q[r] != '0);
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the single-cycle load/branch interlock of the in-order MIPS pipeline.
- Instead of comparing against fixed EX/MEM destination fields, it keeps a per-register countdown scoreboard. Each countdown holds the number of cycles until that register's result can be forwarded.
- Generates the ID-stage stall for any configured load or ALU latency, with a stricter rule for branches resolved in ID.
- Sits beside the decoder; also exports a stall-cause code and a saturating stall-cycle performance counter.

Parameters:
- NREG, 32, number of architectural registers; register 0 is hardwired zero and never tracked.
- RW, 5, register index width; must satisfy 2^RW >= NREG.
- ALU_LAT, 1, countdown loaded when an ALU-writing instruction issues (1..7).
- LOAD_LAT, 2, countdown loaded when a load issues (ALU_LAT..7).
- CNT_W, 3, countdown width; must hold LOAD_LAT.
- PERF_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ID_valid  in  1  a real instruction occupies ID.
- ID_rs  in  RW  source register 1.
- ID_rt  in  RW  source register 2.
- ID_useRs  in  1  instruction reads rs.
- ID_useRt  in  1  instruction reads rt.
- ID_rw  in  RW  destination register.
- ID_regWrite  in  1  instruction writes ID_rw from the ALU path.
- ID_memToReg  in  1  instruction is a load into ID_rw; takes precedence over ID_regWrite.
- ID_uncertainJump  in  1  branch/jump-register that needs its operands in ID.
- ID_flush  in  1  ID instruction is squashed this cycle.
- stall  out  1  hold PC and IF/ID; insert a bubble into EX.
- stall_cause  out  2  0 none, 1 ALU-dependent branch, 2 load-use, 3 branch on pending load.
- stall_cycles  out  PERF_W  saturating count of stalled cycles.
- pend_mask  out  NREG  bit r set when cnt[r] != 0.

Behaviour:
- State: cnt[1..NREG-1] (CNT_W each), a per-register pending-load bit, and stall_cycles. On reset (rst_n low, asynchronous, any time, including mid-stall):
  - all cnt = 0 and all load bits = 0;
  - stall_cycles = 0;
  - consequently stall = 0, stall_cause = 0, pend_mask = 0.
- Source check: a source is checked only when its use bit is 1, its index is nonzero, and ID_valid=1 and ID_flush=0.
  - Let need = 0 if ID_uncertainJump, else 1.
  - A checked source r is hazardous when cnt[r] > need.
- stall: combinational; true when either checked source is hazardous.
- stall_cause (combinational) for the worst hazardous source:
  - 2 if the instruction is not a branch and the source has its pending-load bit set;
  - 3 if the instruction is a branch and the source has its pending-load bit set;
  - 1 if the instruction is a branch and the source's pending-load bit is clear;
  - 0 when there is no stall.
  - Precedence: 3 > 2 > 1.
- Issue: the ID instruction issues at a rising edge when ID_valid, !ID_flush, !stall and ID_rw != 0.
  - If ID_memToReg: cnt[ID_rw] <= LOAD_LAT and its load bit <= 1.
  - Else if ID_regWrite: cnt[ID_rw] <= ALU_LAT and its load bit <= 0.
- Decrement: every other nonzero cnt decrements by 1 per cycle. When a cnt reaches 0, its load bit clears.
- Same register, same edge: if a register is both reissued and decrementing on the same edge, the issue value wins (WAW overwrite, no max).
- Stall behaviour: a stalled or flushed instruction causes no scoreboard update, but decrements still occur, so stalls always resolve within LOAD_LAT-1 cycles (LOAD_LAT for branches).
- stall_cycles: increments on each edge where stall=1; holds at all-ones.
- Defaults: the default latencies reproduce the classic rules.
  - Load-use: 1 bubble.
  - Branch after ALU: 1 bubble.
  - Branch after load: 2 bubbles.

Test Plan:
- Reset then idle -> stall=0, pend_mask=0, stall_cycles=0; assert rst_n low mid-countdown -> all outputs 0 immediately, without waiting for a clock edge.
- Load r8, then add reading r8 -> stall=1, cause=2 for exactly 1 cycle; stall_cycles=1; pend_mask bit 8 clears 2 cycles after load issue.
- ALU write r9, then beq using r9 (uncertainJump=1) -> stall 1 cycle, cause=1; a non-branch consumer of r9 gets no stall.
- Load r10, then jr r10 -> stall 2 cycles: cause=3 in both cycles; stall_cycles=2.
- Write r0 by load, then consumer of r0 -> no stall, pend_mask=0; consumer with ID_flush=1 or ID_valid=0 -> no stall and no issue.
- Load r11, then ALU write r11 on the next issuing cycle -> cnt[11]=ALU_LAT and load bit cleared; a following branch on r11 stalls with cause=1. Also rerun with LOAD_LAT=4 -> load-use consumer stalls 3 cycles.
